// File: rtl/svm_feature_packer.sv
// svm_feature_packer: collects a stream of signed feature elements into
// packed NBITS*F_WIDTH vectors, alternating valence/arousal per vector.
// Ports: clk, rst (sync, active-high); sin_feature/sin_valid/sin_last/
// sin_ready element stream in; out_features/fout_valid/fout_ready/
// fout_modality vector out; frame_err sticky framing-violation flag.
// Build option: define SVM_FEATURE_PACKER_PING_PONG_EN for two buffers
// (one fills while the other is held); default is a single buffer.
module svm_feature_packer #(
  parameter int NBITS       = 9,
  parameter int F_WIDTH     = 214,
  parameter int LOG_F_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBITS-1:0]         sin_feature,
  input  logic                     sin_valid,
  input  logic                     sin_last,
  output logic                     sin_ready,
  output logic [NBITS*F_WIDTH-1:0] out_features,
  output logic                     fout_valid,
  input  logic                     fout_ready,
  output logic                     fout_modality,
  output logic                     frame_err
);

  localparam int W = NBITS * F_WIDTH;
  localparam logic [LOG_F_WIDTH-1:0] LAST_IDX =
    LOG_F_WIDTH'(F_WIDTH - 1);

`ifdef SVM_FEATURE_PACKER_PING_PONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 st_q [NB];
  state_e                 st_d [NB];
  logic [W-1:0]           fbuf_q [NB];
  logic [LOG_F_WIDTH-1:0] idx_q;
  logic                   ready_q;
  logic                   ready_d;
  logic                   mod_q;
  logic                   err_q;
  logic                   wr_sel;
  logic                   rd_sel;
  logic                   acc;
  logic                   hs;
  logic                   done;

`ifdef SVM_FEATURE_PACKER_PING_PONG_EN
  logic wr_q;
  logic rd_q;
  assign wr_sel = wr_q;
  assign rd_sel = rd_q;
`else
  assign wr_sel = 1'b0;
  assign rd_sel = 1'b0;
`endif

  assign acc  = sin_valid & ready_q;
  assign hs   = fout_valid & fout_ready;
  assign done = sin_last | (idx_q == LAST_IDX);

  assign sin_ready     = ready_q;
  assign fout_valid    = (st_q[rd_sel] == HOLD);
  assign out_features  = fbuf_q[rd_sel];
  assign fout_modality = mod_q;
  assign frame_err     = err_q;

  // Release and completion may hit different buffers in one cycle.
  always_comb begin
    st_d = st_q;
    if (hs) st_d[rd_sel] = FILL;
    if (acc && done) st_d[wr_sel] = HOLD;
    ready_d = 1'b0;
    for (int i = 0; i < NB; i++)
      if (st_d[i] == FILL) ready_d = 1'b1;
  end

  // Buffers are zeroed on release, so short vectors
  // need no explicit zero-fill of the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        st_q[i]   <= FILL;
        fbuf_q[i] <= '0;
      end
      idx_q   <= '0;
      ready_q <= 1'b0;
      mod_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SVM_FEATURE_PACKER_PING_PONG_EN
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      ready_q <= ready_d;
      if (hs) begin
        fbuf_q[rd_sel] <= '0;
        mod_q          <= ~mod_q;
`ifdef SVM_FEATURE_PACKER_PING_PONG_EN
        rd_q           <= ~rd_q;
`endif
      end
      if (acc) begin
        fbuf_q[wr_sel][int'(idx_q)*NBITS +: NBITS] <= sin_feature;
        if (done) begin
          idx_q <= '0;
`ifdef SVM_FEATURE_PACKER_PING_PONG_EN
          wr_q  <= ~wr_q;
`endif
        end else begin
          idx_q <= idx_q + 1'b1;
        end
        // Short (early last) or long (no last at final slot).
        if (sin_last != (idx_q == LAST_IDX)) err_q <= 1'b1;
      end
    end
  end

endmodule
